// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the memory-port arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
  typedef enum logic [1:0] {G_NONE = 2'b00, G_IF = 2'b01, G_DR = 2'b10, G_DW = 2'b11} grant_t;
  typedef enum logic {SRC_F = 1'b0, SRC_D = 1'b1} src_t;
  localparam logic [31:0] ALIGN_MASK = 32'h3;
endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: 2-way round-robin between fetch and data; on a tie the side not served last wins.
module mem_rr_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic       req_f,
  input  logic       req_d,
  input  src_t       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req_f & (~req_d | (last == SRC_D));
  assign gnt[1] = req_d & (~req_f | (last == SRC_F));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data-stage read/write channels.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ack,
  output logic        if_err,
  input  logic        mem_read_req,
  input  logic [31:0] mem_read_addr,
  output logic [31:0] mem_read_data,
  output logic        mem_read_ack,
  input  logic        mem_write_req,
  input  logic [31:0] mem_write_addr,
  input  logic [31:0] mem_write_data,
  output logic        mem_write_ack,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic [1:0]  grant
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t state, state_d;
  grant_t owner, owner_d;
  src_t last, last_d;
  logic [1:0] gnt;
  logic [CW-1:0] cnt, cnt_d;
  logic bus_req_d, bus_we_d, pick_w, aligned, to_hit, fin, fin_err;
  logic [31:0] bus_addr_d, bus_wdata_d, pick_addr, fin_data;

  mem_rr_arbiter u_rr (
    .req_f(if_req),
    .req_d(mem_read_req | mem_write_req),
    .last (last),
    .gnt  (gnt)
  );

  // a pending read always beats a pending write inside the data requester
  assign pick_w    = gnt[1] & ~mem_read_req;
  assign pick_addr = gnt[0] ? if_addr : (mem_read_req ? mem_read_addr : mem_write_addr);
  assign aligned   = (pick_addr & ALIGN_MASK) == '0;
  assign to_hit    = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign grant     = owner;

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    last_d      = last;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    cnt_d       = cnt;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_data    = '0;
    if (state == S_IDLE) begin
      if (gnt != 2'b00) begin
        owner_d   = gnt[0] ? G_IF : (pick_w ? G_DW : G_DR);
        last_d    = gnt[1] ? SRC_D : SRC_F;
        state_d   = aligned ? S_BUS : S_RESP;
        bus_req_d = aligned;
        fin       = ~aligned;
        fin_err   = ~aligned;
        if (aligned) begin
          bus_we_d    = pick_w;
          bus_addr_d  = pick_addr;
          bus_wdata_d = mem_write_data;
          cnt_d       = '0;
        end
      end
    end else if (state == S_BUS) begin
      // an ack landing on the timeout cycle still counts as success
      if (bus_ack || to_hit) begin
        state_d   = S_RESP;
        bus_req_d = 1'b0;
        fin       = 1'b1;
        fin_err   = ~bus_ack;
        fin_data  = (bus_ack && !bus_we) ? bus_rdata : '0;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end else begin
      state_d = S_IDLE;
      owner_d = G_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      owner         <= G_NONE;
      last          <= SRC_F;
      cnt           <= '0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      busy          <= 1'b0;
      if_ack        <= 1'b0;
      if_err        <= 1'b0;
      if_data       <= '0;
      mem_read_ack  <= 1'b0;
      mem_write_ack <= 1'b0;
      mem_read_data <= '0;
      mem_err       <= 1'b0;
    end else begin
      state         <= state_d;
      owner         <= owner_d;
      last          <= last_d;
      cnt           <= cnt_d;
      bus_req       <= bus_req_d;
      bus_we        <= bus_we_d;
      bus_addr      <= bus_addr_d;
      bus_wdata     <= bus_wdata_d;
      busy          <= state_d != S_IDLE;
      if_ack        <= fin && owner_d == G_IF;
      mem_read_ack  <= fin && owner_d == G_DR;
      mem_write_ack <= fin && owner_d == G_DW;
      if (fin && owner_d == G_IF) begin
        if_data <= fin_data;
        if_err  <= fin_err;
      end
      if (fin && owner_d == G_DR) mem_read_data <= fin_data;
      if (fin && owner_d != G_IF) mem_err <= fin_err;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic if_req = 1'b0, mem_read_req = 1'b0, mem_write_req = 1'b0, bus_ack = 1'b0;
  logic [31:0] if_addr = '0, mem_read_addr = '0, mem_write_addr = '0, mem_write_data = '0, bus_rdata = '0;
  logic [31:0] if_data, mem_read_data, bus_addr, bus_wdata;
  logic if_ack, if_err, mem_read_ack, mem_write_ack, mem_err, bus_req, bus_we, busy;
  logic [1:0] grant;
  int n_vec = 0, n_err = 0;
  bit m_last;
  logic [31:0] e_if_data, e_rd_data;
  logic e_if_err, e_mem_err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack), .if_err(if_err),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_read_ack(mem_read_ack), .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ack(mem_write_ack), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] acks();
    return 32'({if_ack, mem_read_ack, mem_write_ack});
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
    return a;
  endfunction

  task automatic model_reset();
    m_last = 1'b0;
    e_if_data = '0;
    e_rd_data = '0;
    e_if_err = 1'b0;
    e_mem_err = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_acks"}, acks(), 0);
    check({tag, "_bus_req"}, 32'(bus_req), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {if_req, mem_read_req, mem_write_req, bus_ack} = '0;
    @(negedge clk);
    check_idle("do_reset");
    reset = 1'b1;
    model_reset();
  endtask

  // Called at a negedge with the DUT about to sample in IDLE; waits < 0 means the memory never answers.
  task automatic run_one(input int waits, input logic [31:0] rd);
    bit d_win, is_wr, mis, tout, err;
    logic [1:0] eg;
    logic [2:0] ea;
    logic [31:0] a, wd, data;
    int n;
    d_win = (mem_read_req | mem_write_req) && (!if_req || !m_last);
    m_last = d_win;
    is_wr = d_win && !mem_read_req;
    a = !d_win ? if_addr : (mem_read_req ? mem_read_addr : mem_write_addr);
    wd = mem_write_data;
    eg = !d_win ? 2'b01 : (is_wr ? 2'b11 : 2'b10);
    ea = !d_win ? 3'b100 : (is_wr ? 3'b001 : 3'b010);
    mis = a[1:0] != 2'b00;
    tout = 1'b0;
    @(negedge clk);
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 1);
    if (!mis) begin
      check("bus_addr", bus_addr, a);
      check("bus_we", 32'(bus_we), 32'(is_wr));
      if (is_wr) check("bus_wdata", bus_wdata, wd);
      tout = !(waits >= 0 && waits < TO);
      n = tout ? TO - 1 : waits;
      for (int j = 0; j < n; j++) begin
        check("bus_req_wait", 32'(bus_req), 1);
        check("acks_wait", acks(), 0);
        @(negedge clk);
      end
      check("bus_req_last", 32'(bus_req), 1);
      check("acks_last", acks(), 0);
      if (!tout) begin
        bus_ack = 1'b1;
        bus_rdata = rd;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
    end
    err = mis || tout;
    data = (err || is_wr) ? 32'h0 : rd;
    if (!d_win) begin
      e_if_data = data;
      e_if_err = err;
    end else begin
      e_mem_err = err;
      if (!is_wr) e_rd_data = data;
    end
    check("bus_req_done", 32'(bus_req), 0);
    check("acks", acks(), 32'(ea));
    check("grant_resp", 32'(grant), 32'(eg));
    check("if_data", if_data, e_if_data);
    check("if_err", 32'(if_err), 32'(e_if_err));
    check("mem_read_data", mem_read_data, e_rd_data);
    check("mem_err", 32'(mem_err), 32'(e_mem_err));
    if (!d_win) if_req = 1'b0;
    else if (is_wr) mem_write_req = 1'b0;
    else mem_read_req = 1'b0;
    @(negedge clk);
    check_idle("post");
  endtask

  initial begin
    @(negedge clk);
    check_idle("reset");
    check("rst_if_data", if_data, 0);
    check("rst_rd_data", mem_read_data, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_errs", 32'({if_err, mem_err, bus_we}), 0);
    reset = 1'b1;
    model_reset();
    if_req = 1'b1; if_addr = 32'h100;
    run_one(2, 32'hCAFEBABE);
    do_reset();
    if_req = 1'b1; if_addr = 32'h300;
    mem_write_req = 1'b1; mem_write_addr = 32'h200; mem_write_data = 32'h12345678;
    run_one(0, $urandom);
    run_one(1, $urandom);
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1; if_addr = 32'h400 + 32'(k * 4);
      mem_read_req = 1'b1; mem_read_addr = 32'h500 + 32'(k * 8);
      mem_write_req = 1'b1; mem_write_addr = 32'h600; mem_write_data = 32'hA5A50000 | 32'(k);
      run_one(0, $urandom);
    end
    if_req = 1'b0; mem_read_req = 1'b0;
    run_one(0, $urandom);
    mem_read_req = 1'b1; mem_read_addr = 32'h203;
    run_one(0, 32'hFFFFFFFF);
    if_req = 1'b1; if_addr = 32'h40;
    run_one(-1, $urandom);
    if_req = 1'b1;
    run_one(3, 32'h0BADF00D);
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    check("mid_bus_req", 32'(bus_req), 1);
    #2 reset = 1'b0;
    #1 check("mid_rst_bus_req", 32'(bus_req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    if_req = 1'b0;
    @(negedge clk);
    check_idle("mid_rst");
    reset = 1'b1;
    model_reset();
    if_req = 1'b1; if_addr = 32'h84;
    run_one(1, 32'h13579BDF);
    for (int i = 0; i < 300; i++) begin
      if (!if_req && $urandom_range(1) == 1) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      if (!mem_read_req && $urandom_range(1) == 1) begin
        mem_read_req = 1'b1; mem_read_addr = rnd_addr();
      end
      if (!mem_write_req && $urandom_range(1) == 1) begin
        mem_write_req = 1'b1; mem_write_addr = rnd_addr(); mem_write_data = $urandom;
      end
      if (if_req || mem_read_req || mem_write_req) begin
        run_one(($urandom_range(7) == 0) ? -1 : int'($urandom_range(3)), $urandom);
      end else begin
        bus_ack = 1'($urandom_range(1));
        @(negedge clk);
        bus_ack = 1'b0;
        check_idle("quiet");
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
